// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready bus between fetch and imem.
// master = fetch side, slave = memory side.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, imem handshake, IF/ID register,
// and delay-slot-aware redirect with a one-entry pending target.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    fetch_stage_if.master imem,
    input  logic          branch,
    input  logic          bcres,
    input  logic [31:0]   btarget,
    input  logic          jump,
    input  logic [31:0]   jtarget,
    output logic [31:0]   if_id_instr,
    output logic [31:0]   if_id_pc4,
    output logic          if_id_valid
);

    logic [31:0] pc;
    logic        run;
    logic        pend_v;
    logic [31:0] pend_tgt;

    logic        done;
    logic        redirect;
    logic [31:0] tgt;
    logic [31:0] pc4;

    assign imem.imem_addr = pc;
    assign imem.imem_req  = run & ~stall;

    assign done     = imem.imem_req & imem.imem_ready;
    assign redirect = if_id_valid & ~stall & ((branch & bcres) | jump);
    assign tgt      = jump ? jtarget : btarget;
    assign pc4      = pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            run      <= 1'b0;
            pend_v   <= 1'b0;
            pend_tgt <= 32'd0;
        end else begin
            run <= 1'b1;
            if (done) begin
                if (redirect) begin
                    pc <= tgt;
                end else if (pend_v) begin
                    pc     <= pend_tgt;
                    pend_v <= 1'b0;
                end else begin
                    pc <= pc4;
                end
            end else if (redirect) begin
                // delay slot still outstanding: remember where to go next
                pend_v   <= 1'b1;
                pend_tgt <= tgt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_instr <= 32'd0;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            if (done) begin
                if_id_instr <= imem.imem_rdata;
                if_id_pc4   <= pc4;
                if_id_valid <= 1'b1;
            end else begin
                if_id_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS core. It sits directly upstream of the decode stage, where branch conditions are evaluated. It owns the PC register, drives the instruction-memory request/ready handshake and fills the IF/ID pipeline register. It also accepts the decode-stage redirect (taken branch or jump) and applies it after the architectural delay slot, buffering the redirect if the delay-slot fetch is still waiting on memory.

## Interface
- RESET_PC, 32'hBFC0_0000, PC value loaded on reset
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hazard-unit stall; freezes PC and IF/ID
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address (= PC)
- imem_ready  in  1  memory accepts request and returns data this cycle
- imem_rdata  in  32  instruction word, valid when imem_req & imem_ready
- branch  in  1  decode holds a conditional branch
- bcres  in  1  branch condition result from decode
- btarget  in  32  branch target from decode
- jump  in  1  decode holds J/JAL/JR/JALR
- jtarget  in  32  jump target from decode
- if_id_instr  out  32  IF/ID instruction
- if_id_pc4  out  32  IF/ID PC+4 of that instruction
- if_id_valid  out  1  IF/ID holds a real instruction; 0 means bubble

## Operation
- State: pc[31:0], run flag, pend_v, pend_tgt[31:0], IF/ID registers.
- Reset (async, rst_n=0): pc=RESET_PC, run=0, pend_v=0, pend_tgt=0, if_id_instr=0, if_id_pc4=0, if_id_valid=0. run is set to 1 on the first clock edge after reset is released.
- imem_addr = pc, combinational. imem_req = run & ~stall.
- Fetch completes in a cycle where imem_req & imem_ready. No fetch can complete while stalled.
- redirect = if_id_valid & ~stall & ((branch & bcres) | jump). tgt = jump ? jtarget : btarget, so jump has priority when both are asserted.
- The instruction fetched on the cycle after the branch enters decode is the delay slot. It is never squashed.
- PC update, evaluated per edge:
  - stall=1: pc holds, and pend_v/pend_tgt hold.
  - Fetch completes and redirect=1: pc <= tgt. pend_v is unchanged (it is 0 by construction).
  - Fetch completes, redirect=0, pend_v=1: pc <= pend_tgt, pend_v <= 0.
  - Fetch completes, redirect=0, pend_v=0: pc <= pc + 4, with 32-bit wrap (FFFF_FFFC goes to 0000_0000).
  - No completion and redirect=1: pend_v <= 1, pend_tgt <= tgt, pc holds.
  - No completion and redirect=0: all hold.
- IF/ID update:
  - stall=1: hold all three registers.
  - Else, on fetch completion: instr <= imem_rdata, pc4 <= pc + 4, valid <= 1.
  - Else: valid <= 0; instr and pc4 hold (don't-care).
- pc[1:0] is always 00 when targets are aligned. A misaligned target is passed through unchanged; alignment checking is not done in this block.

## Timing
- Fetch to IF/ID: the instruction appears in IF/ID on the edge that ends its completing cycle, giving 1-cycle latency with zero-wait memory.
- Zero-wait memory throughput is 1 instruction/cycle.
- imem_addr stays stable from request to completion, because pc changes only on completion.
- Branch in decode at cycle N with the delay-slot fetch completing in cycle N: the target is fetched in cycle N+1, so there is no lost cycle.
- Delay-slot fetch waiting: the redirect is buffered in pend_tgt. The target is fetched in the cycle after the delay slot completes.
- At most one redirect can be pending. While the delay slot is outstanding, IF/ID carries bubbles, so decode cannot present a second branch.
- Reset asserted mid-fetch abandons the request. imem_req drops to 0 immediately (run=0) and stays 0 for the first cycle after release.

## Test plan
- Reset release with imem_ready=1 constantly:
  - imem_req=0 in the first cycle after release.
  - Addresses BFC0_0000, BFC0_0004, BFC0_0008 then follow on consecutive cycles.
  - if_id_pc4 = BFC0_0004 with valid=1 one cycle after the first request.
- Taken branch: branch=1, bcres=1, btarget=BFC0_0100 with the delay slot at BFC0_0008 completing the same cycle. Required fetch order: …0008, …0100, …0104.
- Same branch with imem_ready=0 for 3 cycles on the delay-slot fetch:
  - imem_addr holds at …0008 and if_id_valid=0 during the wait.
  - The fetch after completion is …0100, then pend_v=0.
- stall=1 for 2 cycles with IF/ID valid:
  - imem_req=0 and pc unchanged.
  - if_id_instr/pc4/valid unchanged.
  - A concurrent branch=1, bcres=1 is ignored, giving no redirect.
- Not-taken branch (bcres=0), and jump=1 with jtarget=0000_0040 while branch=1:
  - Not-taken gives sequential pc+4.
  - Jump takes priority, so the next target fetch is 0000_0040.
- Wrap and async reset:
  - pc at FFFF_FFFC with completion gives next pc 0000_0000.
  - Asserting rst_n=0 between edges clears if_id_valid and sets pc=BFC0_0000 without waiting for a clock edge.
